// File: rtl/iter_alu_if.sv
// iter_alu_if: operation/result handshake bundle for iter_alu
//   master: drives in_valid, op, a, b, flush, out_ready; sees in_ready, out_valid, result
//   slave : the ALU side of the same signals
interface iter_alu_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/iter_alu.sv
// iter_alu: RV-style ALU with single-cycle logic ops and iterative mul/div
//   clk, rst : clock and synchronous active-high reset
//   bus      : iter_alu_if.slave (in_valid/in_ready/op/a/b, flush, out_valid/out_ready/result)
module iter_alu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input logic       clk,
    input logic       rst,
    iter_alu_if.slave bus
);
    localparam int CW = SHAMT_W + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, MULT, DIVI, DONE} state_t;
    state_t            r_state;
    logic [4:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_result;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_nq;
    logic              r_nr;
    logic              r_out_valid;
    logic              r_in_ready;
    logic [SHAMT_W-1:0] w_sh;
    logic [XLEN-1:0]   w_alu;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_bz;
    logic              w_ovf;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mres;
    logic [XLEN:0]     w_dsh;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_nx;
    logic [XLEN-1:0]   w_quo_nx;
    logic [XLEN-1:0]   w_dres;
    logic              w_last;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign w_sh     = bus.b[SHAMT_W-1:0];
    assign w_is_mul = bus.op >= 5'd11 && bus.op <= 5'd14;
    assign w_is_div = bus.op >= 5'd15 && bus.op <= 5'd18;
    assign w_bz     = bus.b == '0;
    assign w_ovf    = (bus.op == 5'd15 || bus.op == 5'd17) && bus.a == MIN_NEG && bus.b == '1;
    // Operand signs only matter for the signed mul/div flavours; magnitudes feed the iterators.
    assign w_sa = bus.a[XLEN-1] & (bus.op == 5'd12 || bus.op == 5'd13 || bus.op == 5'd15 || bus.op == 5'd17);
    assign w_sb = bus.b[XLEN-1] & (bus.op == 5'd12 || bus.op == 5'd15 || bus.op == 5'd17);
    assign w_ma = w_sa ? -bus.a : bus.a;
    assign w_mb = w_sb ? -bus.b : bus.b;
    // Single-cycle results; the div entries only cover the divide-by-zero and overflow bypasses.
    always_comb begin
        w_alu = '0;
        case (bus.op)
            5'd0:         w_alu = bus.a + bus.b;
            5'd1:         w_alu = bus.a - bus.b;
            5'd2:         w_alu = bus.a & bus.b;
            5'd3:         w_alu = bus.a | bus.b;
            5'd4:         w_alu = bus.a ^ bus.b;
            5'd5:         w_alu = bus.a << w_sh;
            5'd6:         w_alu = bus.a >> w_sh;
            5'd7:         w_alu = $signed(bus.a) >>> w_sh;
            5'd8:         w_alu = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            5'd9:         w_alu = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            5'd10:        w_alu = bus.b;
            5'd15, 5'd16: w_alu = w_bz ? '1 : bus.a;
            5'd17, 5'd18: w_alu = w_bz ? bus.a : '0;
            default:      w_alu = '0;
        endcase
    end
    // Shift-add step: low half starts as the multiplier and is consumed LSB first.
    assign w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_acc_nx = {w_sum, r_acc[XLEN-1:1]};
    assign w_prod   = r_nq ? -w_acc_nx : w_acc_nx;
    assign w_mres   = r_op == 5'd11 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    // Restoring step: r_a shifts the dividend out and the quotient bits in.
    assign w_dsh    = {r_rem, r_a[XLEN-1]};
    assign w_ge     = w_dsh >= {1'b0, r_b};
    assign w_rem_nx = w_ge ? XLEN'(w_dsh - {1'b0, r_b}) : w_dsh[XLEN-1:0];
    assign w_quo_nx = {r_a[XLEN-2:0], w_ge};
    assign w_dres   = (r_op == 5'd15 || r_op == 5'd16) ? (r_nq ? -w_quo_nx : w_quo_nx)
                                                       : (r_nr ? -w_rem_nx : w_rem_nx);
    assign w_last   = r_cnt == CW'(XLEN - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_nq        <= 1'b0;
            r_nr        <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (bus.flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_op       <= bus.op;
                    r_a        <= w_ma;
                    r_b        <= w_mb;
                    r_acc      <= {{XLEN{1'b0}}, w_mb};
                    r_rem      <= '0;
                    r_cnt      <= '0;
                    r_nq       <= w_sa ^ w_sb;
                    r_nr       <= w_sa;
                    r_in_ready <= 1'b0;
                    if (w_is_mul) begin
                        r_state <= MULT;
                    end else if (w_is_div && !w_bz && !w_ovf) begin
                        r_state <= DIVI;
                    end else begin
                        r_state     <= DONE;
                        r_result    <= w_alu;
                        r_out_valid <= 1'b1;
                    end
                end
                MULT: begin
                    r_acc <= w_acc_nx;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_result    <= w_mres;
                        r_out_valid <= 1'b1;
                    end
                end
                DIVI: begin
                    r_a   <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_result    <= w_dres;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed and random checks of iter_alu against an arithmetic reference model
module tb_iter_alu;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad = 0;
    iter_alu_if #(.XLEN(32)) bus();
    iter_alu #(.XLEN(32), .SHAMT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed as_ = a;
        int signed bs = b;
        longint    la = longint'(as_);
        longint    lb = longint'(bs);
        logic [63:0] pss = la * lb;
        logic [63:0] psu = la * longint'({32'd0, b});
        logic [63:0] puu = {32'd0, a} * {32'd0, b};
        logic [63:0] sq = la / (b == 0 ? 64'sd1 : lb);
        logic [63:0] sr = la % (b == 0 ? 64'sd1 : lb);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[4:0];
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'(as_ >>> b[4:0]);
            5'd8:  return {31'd0, as_ < bs};
            5'd9:  return {31'd0, a < b};
            5'd10: return b;
            5'd11: return puu[31:0];
            5'd12: return pss[63:32];
            5'd13: return psu[63:32];
            5'd14: return puu[63:32];
            5'd15: return b == 0 ? 32'hFFFF_FFFF : sq[31:0];
            5'd16: return b == 0 ? 32'hFFFF_FFFF : a / b;
            5'd17: return b == 0 ? a : sr[31:0];
            5'd18: return b == 0 ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction
    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 11 && op <= 14) return 33;
        if (op >= 15 && op <= 18 && b != 0 && !((op == 15 || op == 17) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 33;
        return 1;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic start(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = 5'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
    endtask
    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input int el, input string tag);
        int lat = 1;
        start(op, a, b);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_res"}, bus.result, er);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_ovl_clr"}, bus.out_valid, 0);
    endtask
    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        run(5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, "add_wrap");
        run(5'd7, 32'h8000_0000, 32'h21, 32'hC000_0000, 1, "sra");
        run(5'd12, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
        run(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        run(5'd15, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, "div_neg");
        run(5'd17, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, "rem_neg");
        run(5'd16, 32'h5, 32'h0, 32'hFFFF_FFFF, 1, "divu_zero");
        run(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");
        run(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run(op, a, b, ref_res(op, a, b), ref_lat(op, a, b), $sformatf("rnd%0d_op%0d", i, op));
        end
        start(5'd0, 32'h1234, 32'h1111);
        for (int i = 0; i < 10; i++) begin
            chk("hold_result", bus.result, 32'h2345);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_out_valid", bus.out_valid, 1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 5'd0;
        bus.a = 32'd1;
        bus.b = 32'd1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("hs_out_valid", bus.out_valid, 0);
        chk("hs_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("reaccept_valid", bus.out_valid, 1);
        chk("reaccept_result", bus.result, 32'd2);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        start(5'd15, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        repeat (30) @(negedge clk);
        chk("flush_no_result", bus.out_valid, 0);
        start(5'd12, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_out_valid", bus.out_valid, 0);
        chk("rst_mid_in_ready", bus.in_ready, 1);
        chk("rst_mid_result", bus.result, 0);
        run(5'd0, 32'd2, 32'd3, 32'd5, 1, "add_after");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width; equals log2(XLEN).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand/op presented.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port op  input  5  operation select, encoding per REQ-013.
REQ-008 SHALL have port a  input  XLEN  operand A.
REQ-009 SHALL have port b  input  XLEN  operand B.
REQ-010 SHALL have port flush  input  1  abort in-flight operation.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1) for the result handshake.
REQ-012 SHALL have port result  output  XLEN  result, valid only while out_valid=1.

Function
REQ-013 op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB (result=b), 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU; codes 19-31 yield result 0.
REQ-014 Shifts SHALL use b[SHAMT_W-1:0] only; SRA sign-fills from a[XLEN-1].
REQ-015 SLT SHALL compare signed, SLTU unsigned; result is 0 or 1, zero-extended.
REQ-016 MUL returns the low XLEN bits of the product; MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product with signed*signed, signed*unsigned, and unsigned*unsigned operands respectively.
REQ-017 DIV/REM SHALL truncate toward zero; the remainder takes the dividend's sign.
REQ-018 States SHALL be IDLE, MULT, DIVI, DONE; in_ready=1 only in IDLE.
REQ-019 Accept occurs when in_valid and in_ready are both 1 on a rising edge; a, b and op SHALL be registered at accept, and later changes on those inputs SHALL be ignored.
REQ-020 Ops 0-10 and 19-31: IDLE->DONE on accept; out_valid asserts on the cycle after accept (latency 1).
REQ-021 MUL group: IDLE->MULT; a radix-2 shift-add over magnitudes runs for XLEN cycles, applies sign correction, then enters DONE; out_valid asserts XLEN+1 cycles after accept.
REQ-022 DIV group: IDLE->DIVI; a restoring divider over magnitudes runs for XLEN cycles, applies sign correction, then enters DONE; out_valid asserts XLEN+1 cycles after accept.
REQ-023 Divide by zero SHALL bypass DIVI and go directly IDLE->DONE (latency 1), giving quotient all-ones and remainder = a.
REQ-024 Signed overflow (a=most-negative, b=-1) SHALL bypass DIVI (latency 1), giving DIV=a and REM=0.
REQ-025 DONE: out_valid=1 and result is held stable until out_ready=1; on the out_ready edge, go DONE->IDLE and deassert out_valid.
REQ-026 in_ready SHALL stay 0 in DONE even when out_ready=1 (no same-cycle re-accept); a new accept is possible no earlier than the cycle after the result handshake.
REQ-027 flush=1 SHALL force IDLE on the next edge from any state, discarding any pending result; it has priority over accept and over out_ready.
REQ-028 An internal iteration counter of width log2(XLEN)+1 SHALL count 0..XLEN-1 and never wrap in normal operation.
REQ-029 All arithmetic SHALL be performed modulo 2^XLEN except the internal 2*XLEN product accumulator.

Reset
REQ-030 rst=1 SHALL, on the next edge, set state=IDLE, out_valid=0, result=0, counter=0 and operand registers=0; in_ready=1 from the first cycle after reset deasserts.
REQ-031 rst SHALL have priority over flush and over all handshakes, including assertion in the middle of a MULT or DIVI iteration.

Verification
REQ-032 ADD: a=0xFFFFFFFF, b=1 -> result=0x00000000, out_valid on the cycle after accept; SRA with a=0x80000000, b=0x21 -> result=0xC0000000.
REQ-033 MULH: a=0x80000000, b=0x80000000 -> result=0x40000000 at 33 cycles after accept; MULHU with a=b=0xFFFFFFFF -> result=0xFFFFFFFE.
REQ-034 DIV: a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD; REM with the same operands -> result=0xFFFFFFFF; both 33-cycle latency.
REQ-035 DIVU with b=0 and a=5 -> result=0xFFFFFFFF in 1 cycle; REM with a=0x80000000, b=0xFFFFFFFF -> result=0 in 1 cycle.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0 throughout; assert out_ready -> in_ready=1 on the next cycle.
REQ-037 Assert flush at cycle 10 of a DIV, then assert rst mid-MULT -> each returns to IDLE next edge with out_valid=0; a following ADD 2+3 returns 5.
